// File: rtl/pr_pkg.sv
// rtl/pr_pkg.sv - shared types and defaults for the pending-write scoreboard
package pr_pkg;

  localparam int NREGS_DEF  = 64;
  localparam int CNT_W_DEF  = 2;
  localparam int UNIT_W_DEF = 3;

  function automatic int rn_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  localparam int RN_W_DEF = rn_width(NREGS_DEF);

  typedef logic [RN_W_DEF-1:0]   reg_idx_t;
  typedef logic [UNIT_W_DEF-1:0] unit_tag_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/pr_counter_cell.sv
// rtl/pr_counter_cell.sv - per-register pending-write counter and owner tag
// PR_SCOREBOARD_BYPASS_EN selects the combinational next-state busy view.
module pr_counter_cell #(
  parameter int CNT_W  = 2,
  parameter int UNIT_W = 3,
  parameter int INC_W  = 2,
  parameter int DEC_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [INC_W-1:0]  inc,
  input  logic [DEC_W-1:0]  dec,
  input  logic              owner_we,
  input  logic [UNIT_W-1:0] owner_in,
  output logic [CNT_W-1:0]  cnt,
  output logic [UNIT_W-1:0] owner,
  output logic              busy,
  output logic              underflow
);

  localparam int SUM_W = CNT_W + INC_W + DEC_W + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [SUM_W-1:0] avail;
  logic [SUM_W-1:0] take;
  logic [SUM_W-1:0] diff;
  logic [CNT_W-1:0] cnt_next;

  // Claims are counted before frees, so a free only underflows past them.
  always_comb begin
    avail     = SUM_W'(cnt) + SUM_W'(inc);
    take      = SUM_W'(dec);
    diff      = '0;
    underflow = 1'b0;
    cnt_next  = cnt;
    if (flush) begin
      cnt_next = '0;
    end else if (take > avail) begin
      cnt_next  = '0;
      underflow = 1'b1;
    end else begin
      diff     = avail - take;
      cnt_next = (diff > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : diff[CNT_W-1:0];
    end
  end

`ifdef PR_SCOREBOARD_BYPASS_EN
  assign busy = rst_n && !flush && ((inc != '0) || (cnt_next != '0));
`else
  assign busy = (cnt != '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      owner <= '0;
    end else begin
      cnt <= cnt_next;
      if (flush) begin
        owner <= '0;
      end else if (owner_we) begin
        owner <= owner_in;
      end
    end
  end

endmodule

// File: rtl/pr_scoreboard.sv
// rtl/pr_scoreboard.sv - pending-write scoreboard with port-ordered claim acceptance
// Optional PR_SCOREBOARD_BYPASS_EN (in pr_counter_cell) makes reg_busy a next-state view.
module pr_scoreboard
  import pr_pkg::*;
#(
  parameter int NREGS       = NREGS_DEF,
  parameter int ISSUE_PORTS = 2,
  parameter int FREE_PORTS  = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int UNIT_W      = UNIT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [ISSUE_PORTS-1:0]        busy_en,
  input  logic [ISSUE_PORTS*rn_width(NREGS)-1:0] busy_rn,
  input  logic [ISSUE_PORTS*UNIT_W-1:0] busy_unit,
  output logic [ISSUE_PORTS-1:0]        issue_ok,
  input  logic [FREE_PORTS-1:0]         free_en,
  input  logic [FREE_PORTS*rn_width(NREGS)-1:0]  free_rn,
  output logic [NREGS-1:0]              reg_busy,
  output logic [NREGS*UNIT_W-1:0]       owner_unit,
  output logic                          underflow_err
);

  localparam int RN_W  = rn_width(NREGS);
  localparam int IP_W  = $clog2(ISSUE_PORTS + 1);
  localparam int FP_W  = $clog2(FREE_PORTS + 1);
  localparam int CMP_W = CNT_W + IP_W + 1;
  localparam logic [CMP_W-1:0] CNT_MAX = CMP_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0]       cnt [NREGS];
  logic [NREGS-1:0]       uf;
  logic [ISSUE_PORTS-1:0] accepted;
  logic [CMP_W-1:0]       need;

  // Lower ports win; same-cycle frees are deliberately not credited.
  always_comb begin
    issue_ok = '0;
    accepted = '0;
    need     = '0;
    for (int p = 0; p < ISSUE_PORTS; p++) begin
      need = CMP_W'(cnt[busy_rn[p*RN_W +: RN_W]]) + CMP_W'(1);
      for (int q = 0; q < p; q++) begin
        if (accepted[q] && (busy_rn[q*RN_W +: RN_W] == busy_rn[p*RN_W +: RN_W])) begin
          need = need + CMP_W'(1);
        end
      end
      issue_ok[p] = (busy_rn[p*RN_W +: RN_W] == RN_W'(REG_ZERO)) || (need <= CNT_MAX);
      accepted[p] = busy_en[p] && issue_ok[p];
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    logic [IP_W-1:0]   inc;
    logic [FP_W-1:0]   dec;
    logic              owe;
    logic [UNIT_W-1:0] oin;

    always_comb begin
      inc = '0;
      dec = '0;
      owe = 1'b0;
      oin = '0;
      if (r != 0) begin
        for (int p = 0; p < ISSUE_PORTS; p++) begin
          if (accepted[p] && (busy_rn[p*RN_W +: RN_W] == RN_W'(r))) begin
            inc = inc + IP_W'(1);
            owe = 1'b1;
            oin = busy_unit[p*UNIT_W +: UNIT_W];
          end
        end
        for (int f = 0; f < FREE_PORTS; f++) begin
          if (free_en[f] && (free_rn[f*RN_W +: RN_W] == RN_W'(r))) begin
            dec = dec + FP_W'(1);
          end
        end
      end
    end

    pr_counter_cell #(
      .CNT_W  (CNT_W),
      .UNIT_W (UNIT_W),
      .INC_W  (IP_W),
      .DEC_W  (FP_W)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .inc       (inc),
      .dec       (dec),
      .owner_we  (owe),
      .owner_in  (oin),
      .cnt       (cnt[r]),
      .owner     (owner_unit[r*UNIT_W +: UNIT_W]),
      .busy      (reg_busy[r]),
      .underflow (uf[r])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_err <= 1'b0;
    end else if (|uf) begin
      underflow_err <= 1'b1;
    end
  end

endmodule
